mips_pipe_ctrl: RTL

//  Pipelined successor to the single-cycle decoder: decodes the ID-stage instruction, carries control bundles

---
 rtl/mips_pipe_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: pipelined MIPS control with decode, EX/MEM/WB control stages, stall, flush and forwarding
module mips_pipe_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter bit EN_FWD      = 1'b1,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic              ex_zero,
  output logic              id_ready,
  output logic              flush_id,
  output logic [1:0]        pc_src,
  output logic [3:0]        ex_alu_ctrl,
  output logic [1:0]        ex_alu_a_src,
  output logic [1:0]        ex_alu_b_src,
  output logic              ex_ext_bit,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_write,
  output logic              mem_access,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        wb_data_src,
  output logic              inv,
  output logic              mul_busy
);
  typedef struct packed {
    logic [3:0]        alu;
    logic [1:0]        a_src;
    logic [1:0]        b_src;
    logic              ext;
    logic              beq;
    logic              bne;
    logic              jmp;
    logic              jr;
    logic              mw;
    logic              mr;
    logic              rw;
    logic [1:0]        dsrc;
    logic              ld;
    logic              mul;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } ctl_t;

  ctl_t dec, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic ex_v_q, ex_v_d, mem_v_q, mem_v_d, wb_v_q, wb_v_d, inv_q, inv_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] op, fn;
  logic ok, use_rs, use_rt, haz, redirect, issue;

  function automatic logic dep(input logic v, input ctl_t s, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rt, input logic urs, input logic urt);
    return v & s.rw & (s.dest != '0) & ((urs & (s.dest == rs)) | (urt & (s.dest == rt)));
  endfunction

  function automatic logic [1:0] fsel(input logic mv, input ctl_t m, input logic wv, input ctl_t w,
                                      input logic [REG_AW-1:0] r);
    return (mv & m.rw & (m.dest != '0) & (m.dest == r)) ? 2'b10 :
           (wv & w.rw & (w.dest != '0) & (w.dest == r)) ? 2'b01 : 2'b00;
  endfunction

  assign op = id_inst[31:26];
  assign fn = id_inst[5:0];

  // decode the ID instruction into a control bundle plus its source-register usage
  always_comb begin
    dec = '0;
    ok = 1'b1;
    use_rs = 1'b1;
    use_rt = 1'b0;
    dec.rs = REG_AW'(id_inst[25:21]);
    dec.rt = REG_AW'(id_inst[20:16]);
    dec.dest = REG_AW'(id_inst[20:16]);
    dec.ext = (op == 6'b001100) | (id_inst[15] & (op != 6'b001101));
    case (op)
      6'b000000: begin
        dec.b_src = 2'b01;
        dec.rw = 1'b1;
        dec.dsrc = 2'b11;
        dec.dest = REG_AW'(id_inst[15:11]);
        use_rt = 1'b1;
        case (fn)
          6'b000000: dec.alu = 4'b0100;
          6'b000010: dec.alu = 4'b0101;
          6'b000011: dec.alu = 4'b0110;
          6'b100000: dec.alu = 4'b0000;
          6'b100010: dec.alu = 4'b0001;
          6'b100100: dec.alu = 4'b0010;
          6'b100101: dec.alu = 4'b0011;
          6'b101010: dec.alu = 4'b1000;
          6'b001000: begin dec.jr = 1'b1; dec.rw = 1'b0; dec.dsrc = 2'b00; end
          6'b011000: begin dec.alu = 4'b1001; dec.mul = 1'b1; end
          default:   ok = 1'b0;
        endcase
      end
      6'b100011: begin dec.rw = 1'b1; dec.mr = 1'b1; dec.ld = 1'b1; end
      6'b100000: begin dec.rw = 1'b1; dec.mr = 1'b1; dec.ld = 1'b1; dec.dsrc = 2'b01; end
      6'b101011: begin dec.mw = 1'b1; use_rt = 1'b1; end
      6'b000100: begin dec.alu = 4'b0001; dec.b_src = 2'b01; dec.beq = 1'b1; use_rt = 1'b1; end
      6'b000101: begin dec.alu = 4'b0001; dec.b_src = 2'b01; dec.bne = 1'b1; use_rt = 1'b1; end
      6'b001000: begin dec.rw = 1'b1; dec.dsrc = 2'b11; end
      6'b001100: begin dec.alu = 4'b0010; dec.rw = 1'b1; dec.dsrc = 2'b11; end
      6'b001101: begin dec.alu = 4'b0011; dec.rw = 1'b1; dec.dsrc = 2'b11; end
      6'b001010: begin dec.alu = 4'b1000; dec.rw = 1'b1; dec.dsrc = 2'b11; end
      6'b001111: begin dec.alu = 4'b0111; dec.a_src = 2'b01; dec.rw = 1'b1; dec.dsrc = 2'b11; use_rs = 1'b0; end
      6'b000010: begin dec.jmp = 1'b1; use_rs = 1'b0; end
      6'b000011: begin dec.jmp = 1'b1; dec.rw = 1'b1; dec.dsrc = 2'b10; dec.dest = REG_AW'(5'd31); use_rs = 1'b0; end
      default:   ok = 1'b0;
    endcase
    dec = ok ? dec : '0;
    use_rs = use_rs & ok & id_valid;
    use_rt = use_rt & ok & id_valid;
  end

  assign mul_busy = ex_v_q & ex_q.mul & (cnt_q != 4'd0);
  assign redirect = ex_v_q & (ex_q.jmp | ex_q.jr | (ex_q.beq & ex_zero) | (ex_q.bne & ~ex_zero));
  assign haz = EN_FWD ? dep(ex_v_q & ex_q.ld, ex_q, dec.rs, dec.rt, use_rs, use_rt)
                      : (dep(ex_v_q, ex_q, dec.rs, dec.rt, use_rs, use_rt) |
                         dep(mem_v_q, mem_q, dec.rs, dec.rt, use_rs, use_rt) |
                         dep(wb_v_q, wb_q, dec.rs, dec.rt, use_rs, use_rt));
  assign id_ready = ~rst & ~mul_busy & (redirect | ~haz);
  assign issue = id_ready & ~redirect & id_valid & ok;

  // next-state of the stage registers: MULT holds EX and feeds bubbles to MEM, redirect kills ID
  always_comb begin
    ex_v_d = mul_busy ? ex_v_q : issue;
    ex_d = mul_busy ? ex_q : (issue ? dec : '0);
    mem_v_d = ~mul_busy & ex_v_q;
    mem_d = mul_busy ? '0 : ex_q;
    wb_v_d = mem_v_q;
    wb_d = mem_q;
    cnt_d = mul_busy ? cnt_q - 4'd1 : ((issue & dec.mul) ? 4'(MUL_LATENCY - 1) : 4'd0);
    inv_d = id_ready & ~redirect & id_valid & ~ok;
  end

  // stage registers, multiply counter and invalid-opcode pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q <= 1'b0;
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= 4'd0;
      inv_q <= 1'b0;
    end else begin
      ex_v_q <= ex_v_d;
      mem_v_q <= mem_v_d;
      wb_v_q <= wb_v_d;
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      cnt_q <= cnt_d;
      inv_q <= inv_d;
    end
  end

  assign flush_id = redirect;
  assign pc_src = ~redirect ? 2'b00 : ex_q.jmp ? 2'b11 : ex_q.jr ? 2'b10 : 2'b01;
  assign ex_alu_ctrl = ex_v_q ? ex_q.alu : 4'b0000;
  assign ex_alu_a_src = ex_v_q ? ex_q.a_src : 2'b00;
  assign ex_alu_b_src = ex_v_q ? ex_q.b_src : 2'b00;
  assign ex_ext_bit = ex_v_q & ex_q.ext;
  assign fwd_a = (EN_FWD && ex_v_q) ? fsel(mem_v_q, mem_q, wb_v_q, wb_q, ex_q.rs) : 2'b00;
  assign fwd_b = (EN_FWD && ex_v_q) ? fsel(mem_v_q, mem_q, wb_v_q, wb_q, ex_q.rt) : 2'b00;
  assign mem_write = mem_v_q & mem_q.mw;
  assign mem_access = mem_v_q & mem_q.mr;
  assign wb_reg_write = wb_v_q & wb_q.rw;
  assign wb_dest = wb_v_q ? wb_q.dest : '0;
  assign wb_data_src = wb_v_q ? wb_q.dsrc : 2'b00;
  assign inv = inv_q;
endmodule
